// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button decoder.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

    // Defaults assume a 12 MHz clock: 10 ms debounce, 1 s long press, 200 ms repeat.
    localparam int DEF_DEBOUNCE_CYCLES   = 120000;
    localparam int DEF_LONG_PRESS_CYCLES = 12000000;
    localparam int DEF_REPEAT_CYCLES     = 2400000;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability counter; level flips only after
// DEBOUNCE_CYCLES consecutive synchronized samples disagree with it.
module button_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            // stage p0/p1: metastability guard, inverted to active-high
            sync_p0 <= ~btn_n;
            sync_p1 <= sync_p0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= sat_inc(cnt);
            end
        end
    end

endmodule

// File: rtl/button_decoder.sv
// Debounced push-button classifier: short press, long press and optional
// auto-repeat (enabled by defining BUTTON_REPEAT_EN).
module button_decoder
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic repeat_press
);

    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("button_decoder: cycle parameters must be at least 2");
    end

    logic              deb_level;
    btn_state_t        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              short_nxt, long_nxt;

    function automatic logic [HOLD_W-1:0] sat_inc_hold(input logic [HOLD_W-1:0] v);
        return (v == {HOLD_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n),
        .level (deb_level)
    );

`ifdef BUTTON_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

    logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
    logic             rep_nxt;

    function automatic logic [REP_W-1:0] sat_inc_rep(input logic [REP_W-1:0] v);
        return (v == {REP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt      <= '0;
            repeat_press <= 1'b0;
        end else begin
            rep_cnt      <= rep_cnt_nxt;
            repeat_press <= rep_nxt;
        end
    end
`else
    assign repeat_press = 1'b0;
`endif

    // Pulses are registered so they line up with the registered pressed level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            pressed     <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            pressed     <= deb_level;
            short_press <= short_nxt;
            long_press  <= long_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
`ifdef BUTTON_REPEAT_EN
        rep_cnt_nxt = rep_cnt;
        rep_nxt     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (deb_level) begin
                    state_nxt = ST_PRESSED;
                    hold_nxt  = '0;
                end
            end
            ST_PRESSED: begin
                // release is tested first so it wins over the long threshold
                if (!deb_level) begin
                    state_nxt = ST_IDLE;
                    short_nxt = 1'b1;
                end else if (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1)) begin
                    state_nxt = ST_HELD;
                    long_nxt  = 1'b1;
`ifdef BUTTON_REPEAT_EN
                    rep_cnt_nxt = '0;
`endif
                end else begin
                    hold_nxt = sat_inc_hold(hold_cnt);
                end
            end
            ST_HELD: begin
                if (!deb_level) begin
                    state_nxt = ST_IDLE;
`ifdef BUTTON_REPEAT_EN
                end else if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
                    rep_nxt     = 1'b1;
                    rep_cnt_nxt = '0;
                end else begin
                    rep_cnt_nxt = sat_inc_rep(rep_cnt);
`endif
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_button_decoder.sv
// Self-checking bench for button_decoder with short debounce/long/repeat timings.
module tb_button_decoder;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;
`ifdef BUTTON_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_n = 1'b1;
    logic pressed, short_press, long_press, repeat_press;

    button_decoder #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .REPEAT_CYCLES     (R)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_n        (btn_n),
        .pressed      (pressed),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_press (repeat_press)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: raw samples delayed two edges, a window of the last D
    // synchronized samples, and press classification by edge distance from the rise.
    bit m_s1, m_s2, m_deb, m_p;
    bit win_q[$];
    int rise_e = 0;
    bit e_short, e_long, e_rep;

    int cnt_short, cnt_long, cnt_rep, cnt_pcyc, long_off, rise_dut;
    logic prev_pressed = 1'b0;

    typedef struct {
        int hold;
        int exp_short;
        int exp_long;
        int exp_rep;
        int exp_pcyc;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        bit used, p_old, all_diff;
        e_short = 1'b0;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        if (!rst_n) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            m_deb = 1'b0;
            m_p = 1'b0;
            win_q.delete();
        end else begin
            used = m_s2;
            m_s2 = m_s1;
            m_s1 = ~btn_n;
            p_old = m_p;
            m_p = m_deb;
            win_q.push_back(used);
            if (win_q.size() > D) void'(win_q.pop_front());
            all_diff = (win_q.size() == D);
            foreach (win_q[i]) if (win_q[i] == m_deb) all_diff = 1'b0;
            if (all_diff) m_deb = ~m_deb;
            if (!p_old && m_p) rise_e = cyc;
            if (p_old && !m_p && (cyc - rise_e) <= L) e_short = 1'b1;
            if (m_p && (cyc - rise_e) == L) e_long = 1'b1;
            if (REP_ON && m_p && (cyc - rise_e) > L && ((cyc - rise_e - L) % R) == 0) e_rep = 1'b1;
        end
    endtask

    task automatic clear_counts();
        cnt_short = 0;
        cnt_long  = 0;
        cnt_rep   = 0;
        cnt_pcyc  = 0;
        long_off  = -1;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("pressed", pressed, m_p);
        check("short_press", short_press, e_short);
        check("long_press", long_press, e_long);
        check("repeat_press", repeat_press, e_rep);
        check("pulse_exclusive", (32'(short_press) + 32'(long_press) + 32'(repeat_press)) <= 1, 1);
        if (pressed && !prev_pressed) rise_dut = cyc;
        prev_pressed = pressed;
        cnt_short += int'(short_press);
        cnt_long  += int'(long_press);
        cnt_rep   += int'(repeat_press);
        cnt_pcyc  += int'(pressed);
        if (long_press) long_off = cyc - rise_dut;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int len;
        vecs[0] = '{3,  0, 0, 0, 0};
        vecs[1] = '{4,  1, 0, 0, 4};
        vecs[2] = '{10, 1, 0, 0, 10};
        vecs[3] = '{20, 1, 0, 0, 20};
        vecs[4] = '{21, 0, 1, 0, 21};
        vecs[5] = '{40, 0, 1, REP_ON ? 2 : 0, 40};
        vecs[6] = '{50, 0, 1, REP_ON ? 3 : 0, 50};
        clear_counts();

        rst_n = 1'b0;
        btn_n = 1'b0;
        repeat (3) begin
            step();
            check("reset_pressed", pressed, 0);
            check("reset_pulses", {short_press, long_press, repeat_press}, 0);
        end
        btn_n = 1'b1;
        rst_n = 1'b1;
        repeat (10) step();

        for (int v = 0; v < 7; v++) begin
            clear_counts();
            btn_n = 1'b0;
            repeat (vecs[v].hold) step();
            btn_n = 1'b1;
            repeat (40) step();
            check($sformatf("vec%0d_short_cnt", v), cnt_short, vecs[v].exp_short);
            check($sformatf("vec%0d_long_cnt", v), cnt_long, vecs[v].exp_long);
            check($sformatf("vec%0d_repeat_cnt", v), cnt_rep, vecs[v].exp_rep);
            check($sformatf("vec%0d_pressed_cycles", v), cnt_pcyc, vecs[v].exp_pcyc);
            if (vecs[v].exp_long != 0) check($sformatf("vec%0d_long_offset", v), long_off, L);
        end

        // Reset while held past the long threshold, button still down.
        btn_n = 1'b0;
        repeat (30) step();
        rst_n = 1'b0;
        repeat (2) begin
            step();
            check("midhold_reset_pressed", pressed, 0);
            check("midhold_reset_pulses", {short_press, long_press, repeat_press}, 0);
        end
        rst_n = 1'b1;
        clear_counts();
        k = 0;
        while (!pressed && k < 20) begin
            step();
            k++;
        end
        check("rerise_delay", k - 1, D + 2);
        btn_n = 1'b1;
        repeat (30) step();
        check("after_reset_pulses", cnt_short + cnt_long + cnt_rep, 1);
        check("after_reset_short", cnt_short, 1);

        // Button released while reset is active: the press is discarded.
        btn_n = 1'b0;
        repeat (12) step();
        rst_n = 1'b0;
        btn_n = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        clear_counts();
        repeat (30) step();
        check("discarded_press_pulses", cnt_short + cnt_long + cnt_rep, 0);
        check("discarded_press_level", cnt_pcyc, 0);

        // Random bouncy stimulus with occasional resets, checked every cycle.
        for (int seg = 0; seg < 150; seg++) begin
            btn_n = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(5, 60));
            if ($urandom_range(0, 30) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 2)) step();
                rst_n = 1'b1;
            end
            repeat (len) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
